// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter
//   Round-robin arbiter and transaction sequencer that shares one SPI master
//   between NUM_REQ on-chip requesters. The winner's TX word is latched and
//   handed to the master with a start pulse. The master's ready/RX-valid
//   handshake is tracked to completion, then the last received byte goes back
//   to the owner with a one-cycle done pulse. A timeout ends the transaction
//   with an error instead.
//
// Ports
//   i_Clk, i_Rst_L    clock, asynchronous active-low reset
//   i_Req             per-requester request level, held until o_Ack
//   i_Req_Data        packed TX words, requester k at [k*TX_WIDTH +: TX_WIDTH]
//   o_Ack             one-hot pulse: request accepted, data latched
//   o_Done            one-hot pulse: transaction finished
//   o_Resp_Data       response byte, valid with o_Done
//   o_Err             set together with o_Done when the transaction timed out
//   o_Busy            high whenever the FSM is not in IDLE
//   o_Grant_Id        index of the current or last granted requester
//   o_SPI_Start       start pulse to the SPI master
//   o_SPI_TX_Word     word to the SPI master, stable from launch until done
//   i_SPI_TX_Ready    master idle/ready
//   i_SPI_RX_DV       master RX byte valid pulse
//   i_SPI_RX_Byte     master RX byte
module spi_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TX_WIDTH       = 16,
  parameter int RX_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst_L,
  input  logic [NUM_REQ-1:0]           i_Req,
  input  logic [NUM_REQ*TX_WIDTH-1:0]  i_Req_Data,
  output logic [NUM_REQ-1:0]           o_Ack,
  output logic [NUM_REQ-1:0]           o_Done,
  output logic [RX_WIDTH-1:0]          o_Resp_Data,
  output logic                         o_Err,
  output logic                         o_Busy,
  output logic [GW-1:0]                o_Grant_Id,
  output logic                         o_SPI_Start,
  output logic [TX_WIDTH-1:0]          o_SPI_TX_Word,
  input  logic                         i_SPI_TX_Ready,
  input  logic                         i_SPI_RX_DV,
  input  logic [RX_WIDTH-1:0]          i_SPI_RX_Byte
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_DONE
  } state_t;

  state_t                r_State, w_Next;
  logic [GW-1:0]         r_Ptr, r_Grant, w_Win, w_Ptr_Nxt;
  logic [CW-1:0]         r_Cnt;
  logic [RX_WIDTH-1:0]   r_Resp, r_Resp_Out;
  logic [NUM_REQ-1:0]    r_Ack, r_Done, w_Win_Oh, w_Gnt_Oh;
  logic                  r_Err, r_Busy, r_Start;
  logic [TX_WIDTH-1:0]   r_TX_Word, w_Word;
  logic                  w_Found, w_Timeout;
  int                    w_Idx;

  // Search upward from the pointer, wrapping, for the first active request.
  always_comb begin
    w_Found = 1'b0;
    w_Win   = '0;
    w_Idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_Idx = int'(r_Ptr) + i;
      if (w_Idx >= NUM_REQ) w_Idx = w_Idx - NUM_REQ;
      if (!w_Found && i_Req[w_Idx]) begin
        w_Found = 1'b1;
        w_Win   = GW'(w_Idx);
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_REQ; k++) begin : g_oh
      assign w_Win_Oh[k] = w_Found && (w_Win == GW'(k));
      assign w_Gnt_Oh[k] = (r_Grant == GW'(k));
    end
  endgenerate

  assign w_Word    = i_Req_Data[int'(w_Win)*TX_WIDTH +: TX_WIDTH];
  assign w_Ptr_Nxt = (r_Grant == GW'(NUM_REQ-1)) ? '0 : r_Grant + GW'(1);
  // The counter update on this edge would reach TIMEOUT_CYCLES-1.
  assign w_Timeout = (r_Cnt >= CW'(TIMEOUT_CYCLES-2));

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) r_State <= S_IDLE;
    else          r_State <= w_Next;
  end

  always_comb begin
    w_Next = r_State;
    case (r_State)
      S_IDLE:      if (i_SPI_TX_Ready && w_Found) w_Next = S_LAUNCH;
      S_LAUNCH:    w_Next = S_WAIT_BUSY;
      // Timeout wins here so the counter can never step past its limit.
      S_WAIT_BUSY: if (w_Timeout)           w_Next = S_DONE;
                   else if (!i_SPI_TX_Ready) w_Next = S_WAIT_DONE;
      S_WAIT_DONE: if (i_SPI_TX_Ready || w_Timeout) w_Next = S_DONE;
      S_DONE:      w_Next = S_IDLE;
      default:     w_Next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Ptr      <= '0;
      r_Grant    <= '0;
      r_Cnt      <= '0;
      r_Resp     <= '0;
      r_Resp_Out <= '0;
      r_Ack      <= '0;
      r_Done     <= '0;
      r_Err      <= 1'b0;
      r_Busy     <= 1'b0;
      r_Start    <= 1'b0;
      r_TX_Word  <= '0;
    end else begin
      r_Ack   <= '0;
      r_Done  <= '0;
      r_Err   <= 1'b0;
      r_Start <= 1'b0;
      r_Busy  <= (w_Next != S_IDLE);
      case (r_State)
        S_IDLE: if (w_Next == S_LAUNCH) begin
          r_TX_Word  <= w_Word;
          r_Grant    <= w_Win;
          r_Resp     <= '0;
          r_Resp_Out <= '0;
          r_Ack      <= w_Win_Oh;
          r_Start    <= 1'b1;
        end
        S_LAUNCH: r_Cnt <= '0;
        S_WAIT_BUSY: begin
          r_Cnt <= r_Cnt + CW'(1);
          if (w_Next == S_DONE) begin
            r_Done     <= w_Gnt_Oh;
            r_Err      <= 1'b1;
            r_Resp_Out <= '0;
          end
        end
        S_WAIT_DONE: begin
          r_Cnt <= r_Cnt + CW'(1);
          if (i_SPI_RX_DV) r_Resp <= i_SPI_RX_Byte;
          if (w_Next == S_DONE) begin
            r_Done <= w_Gnt_Oh;
            if (i_SPI_TX_Ready) begin
              // A byte landing on the completion cycle is still the last one.
              r_Resp_Out <= i_SPI_RX_DV ? i_SPI_RX_Byte : r_Resp;
            end else begin
              r_Err      <= 1'b1;
              r_Resp_Out <= '0;
            end
          end
        end
        S_DONE: r_Ptr <= w_Ptr_Nxt;
        default: ;
      endcase
    end
  end

  assign o_Ack         = r_Ack;
  assign o_Done        = r_Done;
  assign o_Resp_Data   = r_Resp_Out;
  assign o_Err         = r_Err;
  assign o_Busy        = r_Busy;
  assign o_Grant_Id    = r_Grant;
  assign o_SPI_Start   = r_Start;
  assign o_SPI_TX_Word = r_TX_Word;

endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- Round-robin arbiter and transaction sequencer sharing the single SPI master (spi_top_new) between NUM_REQ on-chip requesters, e.g. ASCON key/nonce loader, status poller, debug port.
- Latches the winning requester's 16-bit TX word and drives the master's start/TX-word inputs.
- Tracks the master's ready/RX-valid signals to completion, then returns the received byte and a done/error pulse to the owning requester.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TX_WIDTH, 16, width of word handed to SPI master
RX_WIDTH, 8, width of byte returned by SPI master
TIMEOUT_CYCLES, 1024, max i_Clk cycles from launch to completion before abort

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  asynchronous active-low reset
i_Req  in  NUM_REQ  per-requester request level; held until o_Ack
i_Req_Data  in  NUM_REQ*TX_WIDTH  packed TX words; requester k uses bits [k*TX_WIDTH +: TX_WIDTH]
o_Ack  out  NUM_REQ  one-hot 1-cycle pulse: request accepted, data latched
o_Done  out  NUM_REQ  one-hot 1-cycle pulse: transaction finished
o_Resp_Data  out  RX_WIDTH  response byte; valid while o_Done is high
o_Err  out  1  high with o_Done when the transaction timed out
o_Busy  out  1  high in every state except IDLE
o_Grant_Id  out  $clog2(NUM_REQ)  index of current/last granted requester
o_SPI_Start  out  1  1-cycle start pulse to SPI master
o_SPI_TX_Word  out  TX_WIDTH  word to SPI master; stable from launch until DONE
i_SPI_TX_Ready  in  1  master idle/ready
i_SPI_RX_DV  in  1  master RX byte valid pulse
i_SPI_RX_Byte  in  RX_WIDTH  master RX byte

Behaviour:
- Reset (async, i_Rst_L=0):
  - All outputs 0; state IDLE.
  - RR pointer 0; timeout counter 0; captured response 0.
  - Reset mid-transaction abandons it silently: no o_Done is issued.
- All outputs registered. FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, DONE.
- IDLE:
  - When |i_Req and i_SPI_TX_Ready=1, select winner g = first set bit searching from pointer upward, wrapping modulo NUM_REQ.
  - Latch i_Req_Data slice g into o_SPI_TX_Word; set o_Grant_Id=g; clear response register; go LAUNCH.
  - If i_SPI_TX_Ready=0, stay IDLE regardless of requests.
- LAUNCH (exactly 1 cycle):
  - o_Ack[g]=1 and o_SPI_Start=1 in this cycle, i.e. 1 cycle after the request is sampled.
  - Timeout counter cleared; go WAIT_BUSY.
- WAIT_BUSY: wait for i_SPI_TX_Ready=0 (master accepted), then go WAIT_DONE.
- WAIT_DONE:
  - Each cycle with i_SPI_RX_DV=1 overwrites the response register with i_SPI_RX_Byte; the last byte wins.
  - On i_SPI_TX_Ready=1 go DONE. An RX_DV arriving in that same cycle is still captured.
- DONE (exactly 1 cycle):
  - o_Done[g]=1; o_Resp_Data = response register; o_Err=0.
  - Pointer = (g+1) mod NUM_REQ; go IDLE.
  - o_Resp_Data holds its value after DONE until the next LAUNCH.
- Timeout:
  - Counter increments every cycle in WAIT_BUSY/WAIT_DONE.
  - On reaching TIMEOUT_CYCLES-1, go DONE with o_Err=1 and o_Resp_Data=0. Pointer advances as normal.
- Requester rules:
  - A requester may drop i_Req before o_Ack; it is then not served unless already latched in IDLE.
  - A request already latched is always completed.
- Requests arriving while o_Busy=1 wait; earliest re-arbitration is the cycle after DONE.
- Back-to-back: minimum 1 IDLE cycle between DONE and the next LAUNCH.
- o_Ack and o_Done are each one-hot or zero; never more than one bit set.
- NUM_REQ=1 degenerates to a sequencer; pointer stays 0.

Test Plan:
- Single requester: i_Req=4'b0001, data 16'hC1A2, master model loops MOSI->MISO, returns RX byte 8'hA2 → o_Ack[0] 1 cycle after request, o_SPI_Start same cycle, o_SPI_TX_Word=16'hC1A2 stable, o_Done[0] with o_Resp_Data=8'hA2, o_Err=0.
- Round-robin fairness: all four requesters held high, data 16'h0000..16'h0003 → grant order 0,1,2,3,0; each o_Ack one-hot; o_Grant_Id sequence matches.
- Pointer wrap: after serving requester 3, assert i_Req=4'b1001 → requester 0 granted, then 3.
- Timeout: master model never drops TX_Ready after Start (TIMEOUT_CYCLES=16) → o_Done[g] with o_Err=1, o_Resp_Data=0 exactly 16 cycles after LAUNCH; next request proceeds normally.
- Reset mid-operation: assert i_Rst_L=0 during WAIT_DONE → all outputs 0 immediately, no o_Done. After release, request 16'hC1A3 completes with response 8'hA3, and requester 0 has first priority.
- Master not ready: hold i_SPI_TX_Ready=0 with i_Req=4'b0010 → no o_Ack or o_SPI_Start. Raise ready → o_Ack[1] 1 cycle later.
